lab2_sequencer: RTL and testbench

Controller that exercises the four-input/four-output lab2 combinational circuit autonomously. It drives {A,B,C,D} through vectors 0..NUM_VECTORS-1 and holds each vector for a settle interval. It then samples {K,L,M,N} into a 16-entry capture memory that the board display logic reads back. It sits between the top-level button/switch logic and the lab2 instance and replaces hand-toggled switch stimulus on hardware.

---
 rtl/lab2_sequencer_if.sv | 23 ++
 rtl/lab2_sequencer.sv | 112 +++++++++++
 tb/tb_lab2_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lab2_sequencer_if.sv
// Handshake/bus bundle between the lab2 sequencer and its user.
// Signals: start/abort control, drive/resp to lab2, status, memory read port.
interface lab2_sequencer_if;
    logic       start;
    logic       abort;
    logic [3:0] drive_abcd;
    logic [3:0] resp_klmn;
    logic       busy;
    logic       done;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
    logic [7:0] signature;

    modport slave (
        input  start, abort, resp_klmn, rd_addr,
        output drive_abcd, busy, done, rd_data, signature
    );

    modport master (
        output start, abort, resp_klmn, rd_addr,
        input  drive_abcd, busy, done, rd_data, signature
    );
endinterface

// File: rtl/lab2_sequencer.sv
// Autonomous stimulus/capture controller for the lab2 combinational circuit.
// Ports: clk, reset (sync, active-high), bus (lab2_sequencer_if.slave):
//   start/abort in, drive_abcd out, resp_klmn in, busy/done out,
//   rd_addr in / rd_data out (combinational read), signature out.
// Optional macro LAB2_SIGNATURE_EN enables the rotate-xor run signature;
// without it signature is tied to 0x00.
module lab2_sequencer #(
    parameter int NUM_VECTORS   = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    lab2_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_VECTORS - 1);
    localparam logic [7:0] RELOAD   = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] idx;
    logic [7:0] settle_cnt;
    logic [3:0] drive_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] mem [16];

`ifdef LAB2_SIGNATURE_EN
    logic [7:0] sig_q;
    assign bus.signature = sig_q;
`else
    assign bus.signature = 8'h00;
`endif

    assign bus.drive_abcd = drive_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.rd_data    = mem[bus.rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 4'd0;
            settle_cnt <= 8'd0;
            drive_q    <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LAB2_SIGNATURE_EN
            sig_q      <= 8'h00;
`endif
            for (int i = 0; i < 16; i++) mem[i] <= 4'd0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state      <= SETTLE;
                        idx        <= 4'd0;
                        drive_q    <= 4'd0;
                        settle_cnt <= RELOAD;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
`ifdef LAB2_SIGNATURE_EN
                        sig_q      <= 8'h00;
`endif
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        drive_q <= 4'd0;
                        busy_q  <= 1'b0;
                    end else if (settle_cnt == 8'd0) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                CAPTURE: begin
                    if (bus.abort) begin
                        // abort wins over the capture write
                        state   <= IDLE;
                        drive_q <= 4'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        mem[idx] <= bus.resp_klmn;
`ifdef LAB2_SIGNATURE_EN
                        sig_q <= {sig_q[6:0], sig_q[7]}
                               ^ {4'b0000, bus.resp_klmn};
`endif
                        if (idx == LAST_IDX) begin
                            state   <= DONE;
                            drive_q <= 4'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state      <= SETTLE;
                            idx        <= idx + 4'd1;
                            drive_q    <= idx + 4'd1;
                            settle_cnt <= RELOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lab2_sequencer.sv
// Directed bench for lab2_sequencer: default instance plus a
// NUM_VECTORS=4 / SETTLE_CYCLES=1 instance for the short-run case.
module tb_lab2_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic mode_lab2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lab2_sequencer_if bus0 ();
    lab2_sequencer_if bus1 ();

    lab2_sequencer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    lab2_sequencer #(
        .NUM_VECTORS   (4),
        .SETTLE_CYCLES (1)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    function automatic logic [3:0] lab2_fn(input logic [3:0] abcd);
        logic a, b, c, d;
        {a, b, c, d} = abcd;
        return {a & b, c | d, a ^ d, ~b};
    endfunction

    always_comb begin
        bus0.resp_klmn = mode_lab2 ? lab2_fn(bus0.drive_abcd)
                                   : bus0.drive_abcd;
    end
    assign bus1.resp_klmn = bus1.drive_abcd;

    typedef struct {
        logic [3:0] addr;
        logic [3:0] exp;
    } rd_vec_t;

    rd_vec_t lab2_tab [6];
    rd_vec_t loop_tab [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read0(input logic [3:0] a, output logic [3:0] d);
        bus0.rd_addr = a;
        #1;
        d = bus0.rd_data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic start0();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc,
                             output int busy_n);
        cyc = 0;
        busy_n = 0;
        while (!bus0.done && cyc < limit) begin
            if (bus0.busy) busy_n++;
            if (bus0.busy && bus0.done) check("busy_done_overlap", 1, 0);
            tick();
            cyc++;
        end
    endtask

    initial begin
        logic [3:0] d;
        logic [7:0] sig_exp;
        int cyc, busy_n;

        lab2_tab[0] = '{4'd0,  4'b0001};
        lab2_tab[1] = '{4'd5,  4'b0110};
        lab2_tab[2] = '{4'd15, 4'b1100};
        lab2_tab[3] = '{4'd3,  4'b0111};
        lab2_tab[4] = '{4'd8,  4'b0011};
        lab2_tab[5] = '{4'd12, 4'b1010};
        for (int i = 0; i < 16; i++) loop_tab[i] = '{4'(i), 4'(i)};

        reset = 1'b0;
        mode_lab2 = 1'b0;
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        bus0.rd_addr = 4'd0;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        bus1.rd_addr = 4'd0;

        // reset state
        do_reset();
        check("rst_busy", bus0.busy, 0);
        check("rst_done", bus0.done, 0);
        check("rst_drive", bus0.drive_abcd, 0);
        check("rst_sig", bus0.signature, 0);
        for (int i = 0; i < 16; i++) begin
            read0(loop_tab[i].addr, d);
            check("rst_mem", d, 0);
        end

        // loopback run at defaults
        start0();
        check("lb_busy_rise", bus0.busy, 1);
        wait_done(200, cyc, busy_n);
        check("lb_done_cycle", cyc, 80);
        check("lb_busy_cycles", busy_n, 80);
        check("lb_busy_at_done", bus0.busy, 0);
        check("lb_drive_idle", bus0.drive_abcd, 0);
        for (int i = 0; i < 16; i++) begin
            read0(loop_tab[i].addr, d);
            check("lb_mem", d, loop_tab[i].exp);
        end
        sig_exp = 8'h00;
`ifdef LAB2_SIGNATURE_EN
        for (int i = 0; i < 16; i++)
            sig_exp = {sig_exp[6:0], sig_exp[7]} ^ {4'b0000, 4'(i)};
`endif
        check("lb_signature", bus0.signature, sig_exp);
        tick();
        check("lb_done_holds", bus0.done, 1);

        // lab2 function model run
        mode_lab2 = 1'b1;
        start0();
        check("l2_done_cleared", bus0.done, 0);
        wait_done(200, cyc, busy_n);
        check("l2_done_cycle", cyc, 80);
        for (int i = 0; i < 6; i++) begin
            read0(lab2_tab[i].addr, d);
            check("l2_mem", d, lab2_tab[i].exp);
        end

        // abort at cycle 12, idx=2 in SETTLE
        mode_lab2 = 1'b0;
        do_reset();
        start0();
        repeat (11) tick();
        check("ab_pre_drive", bus0.drive_abcd, 2);
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        check("ab_busy", bus0.busy, 0);
        check("ab_done", bus0.done, 0);
        check("ab_drive", bus0.drive_abcd, 0);
        for (int i = 0; i < 16; i++) begin
            read0(loop_tab[i].addr, d);
            check("ab_mem", d, (i < 2) ? 4'(i) : 4'd0);
        end
        bus0.abort = 1'b1;
        repeat (3) tick();
        bus0.abort = 1'b0;
        check("ab_idle_noeffect", bus0.busy, 0);

        // start held high: one run, then immediate restart from DONE
        do_reset();
        bus0.start = 1'b1;
        tick();
        wait_done(200, cyc, busy_n);
        check("hold_done_cycle", cyc, 80);
        check("hold_done_busy", bus0.busy, 0);
        tick();
        bus0.start = 1'b0;
        check("hold_restart_done", bus0.done, 0);
        check("hold_restart_busy", bus0.busy, 1);
        cyc = 0;
        while (!bus0.done && cyc < 200) begin
            bus0.start = (cyc == 30);
            tick();
            cyc++;
        end
        bus0.start = 1'b0;
        check("pulse_done_cycle", cyc, 80);

        // reset during CAPTURE of idx=7
        mode_lab2 = 1'b1;
        start0();
        repeat (39) tick();
        check("rc_pre_busy", bus0.busy, 1);
        check("rc_pre_drive", bus0.drive_abcd, 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rc_busy", bus0.busy, 0);
        check("rc_done", bus0.done, 0);
        check("rc_drive", bus0.drive_abcd, 0);
        check("rc_sig", bus0.signature, 0);
        for (int i = 0; i < 16; i++) begin
            read0(loop_tab[i].addr, d);
            check("rc_mem", d, 0);
        end

        // short configuration: 4 vectors, settle 1
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        cyc = 0;
        while (!bus1.done && cyc < 50) begin
            tick();
            cyc++;
        end
        check("sm_done_cycle", cyc, 8);
`ifdef LAB2_SIGNATURE_EN
        check("sm_signature", bus1.signature, 8'h03);
`else
        check("sm_signature", bus1.signature, 8'h00);
`endif
        for (int i = 0; i < 5; i++) begin
            bus1.rd_addr = 4'(i);
            #1;
            check("sm_mem", bus1.rd_data, (i < 4) ? 4'(i) : 4'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
